uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Serial transmit stage that drives the SoC `tx_o` pin from bytes written by the core's peripheral store path.
- Buffers bytes in a small synchronous FIFO and serialises each one as 8N1 UART frames at a fixed bit period.
- Sits directly upstream of the top-level `tx_o` output of `riscv_top`.
- The system testbench and the on-board USB-UART bridge consume its output.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200, integer-truncated); legal range >= 2.
- FIFO_DEPTH, 8, byte entries in the transmit FIFO; power of two, >= 2.

Ports:
- clk_i  input  1  system clock (100 MHz from clocking wizard).
- rst_ni  input  1  asynchronous active-low reset.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i is valid this cycle.
- ready_o  output  1  FIFO can accept a byte this cycle.
- tx_o  output  1  serial line, idle high, registered.
- busy_o  output  1  FIFO non-empty or frame in progress.
- fifo_count_o  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset is asserted asynchronously when rst_ni=0 and released synchronously to clk_i by the instantiating logic. During reset:
  - tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0.
  - FSM is in IDLE, bit and baud counters are 0, FIFO is flushed.
- Reset mid-frame aborts the frame immediately: tx_o returns high without waiting for a clock, and queued bytes are discarded.
- Handshake:
  - A byte is accepted on a rising edge where valid_i && ready_o.
  - ready_o = (count != FIFO_DEPTH), derived from registered count only. It never depends on a same-cycle pop.
  - When full, ready_o=0 and a same-cycle pop does not allow a push.
  - data_i must be held stable while valid_i && !ready_o. valid_i with ready_o=0 has no effect.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
  - No bypass path: a byte pushed into an empty FIFO is popped no earlier than the following cycle.
- FSM states and transitions:
  - IDLE → START when FIFO non-empty: pop head into 8-bit shift register, baud counter cleared.
  - START: tx_o=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx_o=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right and increment bit index. After bit index 7 → STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. Then:
    - if FIFO non-empty: pop and go to START in the same transition (back-to-back frames, no idle gap);
    - else go to IDLE.
- Timing:
  - Byte accepted at edge N into an empty FIFO with FSM in IDLE: pop at edge N+1, tx_o falls at edge N+1 (registered with the state change).
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it is cleared on every state entry from IDLE.
- busy_o = (state != IDLE) || (count != 0), registered.
- fifo_count_o reflects post-edge occupancy.
- No parity, single stop bit, no flow control input.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP);
  - constants DATA_BITS=8 and default CLKS_PER_BIT_100M_115200=868.
- One sub-module, `sync_fifo`: parameterised width/depth; push/pop/full/empty/count; async active-low reset.
- The serialiser FSM lives in `uart_tx_fifo`.

Test Plan:
- Reset, CLKS_PER_BIT=4: hold rst_ni=0 for 5 cycles → tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0. Assert rst_ni=0 mid-frame → tx_o=1 asynchronously, count=0.
- Single byte 0xA5 → tx_o sequence over 40 cycles: 0 | 1,0,1,0,0,1,0,1 | 1. Each bit 4 cycles. busy_o drops after stop bit.
- Back-to-back 0x55 then 0x0F → two frames, 80 contiguous cycles, no idle cycle between the stop bit and the second start bit.
- Fill FIFO_DEPTH=8 plus 1 while the line is busy:
  - ready_o=0 once 8 bytes are accepted;
  - the 9th byte is held until ready_o=1 after the first pop;
  - all 9 bytes emerge in order.
- Push and pop in the same cycle at count=3 → count stays 3, and pointer wrap is exercised past index 7 without corruption.
- CLKS_PER_BIT=868: byte 0x41 → start bit width exactly 868 cycles, frame exactly 8680 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: serialiser states,
// frame geometry and the default bit period for a 100 MHz clock.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS                = 8;
    localparam int BIT_IDX_W                = $clog2(DATA_BITS);
    localparam int CLKS_PER_BIT_100M_115200 = 868;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored, so the
// flags seen by the caller always describe the state before the edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two; count tracks net push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array carries no reset; emptiness is defined by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO. Bytes queued by the core
// are serialised LSB first at CLKS_PER_BIT clocks per bit; consecutive
// bytes leave back to back with no idle gap between stop and start bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_100M_115200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [7:0]                        data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic                              tx_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = counter_width(CLKS_PER_BIT);

    localparam logic [BW-1:0]        BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_e               state_q;
    tx_state_e               state_d;
    logic [BW-1:0]           baud_q;
    logic [BW-1:0]           baud_d;
    logic [BIT_IDX_W-1:0]    bit_q;
    logic [BIT_IDX_W-1:0]    bit_d;
    logic [DATA_BITS-1:0]    shift_q;
    logic [DATA_BITS-1:0]    shift_d;
    logic                    tx_q;
    logic                    tx_d;
    logic                    busy_q;
    logic                    busy_d;

    logic                    push;
    logic                    pop;
    logic [DATA_BITS-1:0]    fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           count_next;

    // Acceptance depends only on the registered occupancy, never on a same-cycle pop.
    assign ready_o = !fifo_full;
    assign push    = valid_i && ready_o;

    assign count_next = fifo_count + CW'(push) - CW'(pop);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Frame sequencer: decides the next state, counters, shift contents and when to pop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                end
            end

            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level and busy flag are computed from the next state so they register with it.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_next != '0);
    end

    // State register; reset forces the line high immediately and abandons any frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a short-bit-period instance for
// frame shape, FIFO and reset behaviour, and a full-rate instance for
// absolute frame timing.
module tb_uart_tx_fifo;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        int         cycles;
        logic       tx;
        logic       ready;
        logic       busy;
        logic [3:0] count;
    } vec_t;

    logic       clk;
    logic       rst_n;

    logic [7:0] data4;
    logic       valid4;
    logic       ready4;
    logic       tx4;
    logic       busy4;
    logic [3:0] count4;

    logic [7:0] data868;
    logic       valid868;
    logic       ready868;
    logic       tx868;
    logic       busy868;
    logic [3:0] count868;

    int checks_total  = 0;
    int checks_passed = 0;

    vec_t       vecs[$];
    logic [7:0] fill_bytes [10];
    logic [7:0] pp_bytes [5];

    uart_tx_fifo #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut4 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_i       (data4),
        .valid_i      (valid4),
        .ready_o      (ready4),
        .tx_o         (tx4),
        .busy_o       (busy4),
        .fifo_count_o (count4)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT (868),
        .FIFO_DEPTH   (8)
    ) dut868 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_i       (data868),
        .valid_i      (valid868),
        .ready_o      (ready868),
        .tx_o         (tx868),
        .busy_o       (busy868),
        .fifo_count_o (count868)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkValue({tag, ".tx"},    32'(tx4),    32'(v.tx));
        checkValue({tag, ".ready"}, 32'(ready4), 32'(v.ready));
        checkValue({tag, ".busy"},  32'(busy4),  32'(v.busy));
        checkValue({tag, ".count"}, 32'(count4), 32'(v.count));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        valid4 = v.valid;
        data4  = v.data;
        for (int c = 0; c < v.cycles; c++) begin
            tick();
            checkOutput($sformatf("vec%0d.c%0d", idx, c), v);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input int n,
                                input logic t, input logic r, input logic b, input int cnt);
        vec_t x;
        x.valid  = v;
        x.data   = d;
        x.cycles = n;
        x.tx     = t;
        x.ready  = r;
        x.busy   = b;
        x.count  = 4'(cnt);
        return x;
    endfunction

    // Offer one byte on the short-period instance, waiting (bounded) for ready.
    task automatic pushByte(input logic [7:0] d, output int waited);
        valid4 = 1'b1;
        data4  = d;
        waited = 0;
        while (!ready4 && waited < 200) begin
            tick();
            waited++;
        end
        checkValue("push_ready_before_timeout", 32'(ready4), 32'd1);
        tick();
        valid4 = 1'b0;
    endtask

    // Decode one 8N1 frame from the short-period line (4 clocks per bit).
    task automatic receiveByte(output logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        ok     = 1'b0;
        b      = 8'h00;
        while (tx4 !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        if (tx4 !== 1'b0) begin
            return;
        end
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            repeat (4) tick();
            b[i] = tx4;
        end
        repeat (4) tick();
        checkValue("stop_bit_high", 32'(tx4), 32'd1);
        ok = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        valid4   = 1'b0;
        data4    = 8'h00;
        valid868 = 1'b0;
        data868  = 8'h00;

        fill_bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h3C, 8'hC3};
        pp_bytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};

        // Single byte 0xA5: bits LSB first 1,0,1,0,0,1,0,1.
        vecs.push_back(mk(1, 8'hA5, 1, 1, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 3, 1, 1, 0, 0));
        // Back-to-back 0x55 then 0x0F; the second push coincides with the first pop.
        vecs.push_back(mk(1, 8'h55, 1, 1, 1, 1, 1));
        vecs.push_back(mk(1, 8'h0F, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 3, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4, 1, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 3, 1, 1, 0, 0));

        // Reset held for five cycles.
        repeat (5) tick();
        checkValue("reset_tx",    32'(tx4),    32'd1);
        checkValue("reset_ready", 32'(ready4), 32'd1);
        checkValue("reset_busy",  32'(busy4),  32'd0);
        checkValue("reset_count", 32'(count4), 32'd0);
        checkValue("reset_tx868", 32'(tx868),  32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        // Fill past depth while the line is busy; the tenth byte must wait for a pop.
        fork
            begin : fill_push
                int w;
                for (int i = 0; i < 10; i++) begin
                    pushByte(fill_bytes[i], w);
                    if (i == 8) begin
                        checkValue("full_count", 32'(count4), 32'd8);
                        checkValue("full_ready", 32'(ready4), 32'd0);
                    end
                    if (i == 9) begin
                        checkValue("held_byte_wait_cycles", 32'(w), 32'd33);
                        checkValue("refill_count", 32'(count4), 32'd8);
                    end
                end
            end
            begin : fill_rx
                logic [7:0] got;
                bit         ok;
                for (int i = 0; i < 10; i++) begin
                    receiveByte(got, ok);
                    checkValue($sformatf("fill_frame%0d_seen", i), 32'(ok), 32'd1);
                    if (ok) begin
                        checkValue($sformatf("fill_byte%0d", i), 32'(got), 32'(fill_bytes[i]));
                    end
                end
            end
        join
        repeat (4) tick();
        checkValue("fill_idle_busy",  32'(busy4),  32'd0);
        checkValue("fill_idle_count", 32'(count4), 32'd0);

        // Push coinciding with a pop at occupancy three keeps the count steady.
        fork
            begin : pp_push
                int w;
                for (int i = 0; i < 4; i++) begin
                    pushByte(pp_bytes[i], w);
                end
                checkValue("pp_count_before", 32'(count4), 32'd3);
                repeat (37) tick();
                checkValue("pp_count_at_pop_edge", 32'(count4), 32'd3);
                checkValue("pp_ready_at_pop_edge", 32'(ready4), 32'd1);
                pushByte(pp_bytes[4], w);
                checkValue("pp_count_push_pop", 32'(count4), 32'd3);
                tick();
                checkValue("pp_count_hold", 32'(count4), 32'd3);
            end
            begin : pp_rx
                logic [7:0] got;
                bit         ok;
                for (int i = 0; i < 5; i++) begin
                    receiveByte(got, ok);
                    checkValue($sformatf("pp_frame%0d_seen", i), 32'(ok), 32'd1);
                    if (ok) begin
                        checkValue($sformatf("pp_byte%0d", i), 32'(got), 32'(pp_bytes[i]));
                    end
                end
            end
        join
        repeat (4) tick();

        // Reset in the middle of a frame with one byte still queued.
        begin : mid_reset
            int w;
            pushByte(8'h00, w);
            pushByte(8'hFF, w);
            repeat (8) tick();
            checkValue("pre_reset_tx",    32'(tx4),    32'd0);
            checkValue("pre_reset_count", 32'(count4), 32'd1);
            #3;
            rst_n = 1'b0;
            #1;
            checkValue("async_reset_tx",    32'(tx4),    32'd1);
            checkValue("async_reset_count", 32'(count4), 32'd0);
            checkValue("async_reset_busy",  32'(busy4),  32'd0);
            checkValue("async_reset_ready", 32'(ready4), 32'd1);
            repeat (3) tick();
            rst_n = 1'b1;
            repeat (50) tick();
            checkValue("post_reset_tx",    32'(tx4),    32'd1);
            checkValue("post_reset_busy",  32'(busy4),  32'd0);
            checkValue("post_reset_count", 32'(count4), 32'd0);
        end

        // Full-rate instance: 0x41 has bit0=1, so the start bit is one clean low pulse.
        begin : full_rate
            int start_len;
            int frame_len;
            valid868 = 1'b1;
            data868  = 8'h41;
            tick();
            valid868 = 1'b0;
            checkValue("r868_count_after_push", 32'(count868), 32'd1);
            checkValue("r868_tx_after_push",    32'(tx868),    32'd1);
            tick();
            checkValue("r868_tx_start", 32'(tx868), 32'd0);
            start_len = 1;
            while (start_len < 2000) begin
                tick();
                if (tx868 !== 1'b0) break;
                start_len++;
            end
            checkValue("r868_start_width", 32'(start_len), 32'd868);
            frame_len = start_len;
            while (busy868 !== 1'b0 && frame_len < 20000) begin
                tick();
                frame_len++;
            end
            checkValue("r868_frame_length", 32'(frame_len), 32'd8680);
            checkValue("r868_idle_tx",      32'(tx868),     32'd1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
